// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one uart_top transmitter
// among NUM_REQ level-request producers. The winner's word is latched, one
// send pulse is issued, tx_busy is tracked to completion and the winner is
// acked. Optional WAIT_DONE watchdog enabled by defining UART_ARB_TIMEOUT_EN.
//
// Handshake: a producer holds req_valid[i] high with stable req_data until
// it sees req_ack[i] (one cycle). Data is captured at grant time, so later
// changes are ignored. req_grant is one-hot from LAUNCH through DONE.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 16,
    parameter int BUSY_WAIT   = 8,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_grant,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic                      tx_send_en,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic                      arb_busy,
    output logic                      err_timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = 20;

    // Marker block: elaborates only for an out-of-range configuration.
    if (NUM_REQ < 2 || NUM_REQ > 8 || BUSY_WAIT < 1 ||
        TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (1 << CNT_W)) begin : g_param_out_of_range
    end

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_START,
        WAIT_DONE,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic [CNT_W-1:0]   cnt;
`ifdef UART_ARB_TIMEOUT_EN
    logic               timeout_hit;
`endif

    // Round-robin search: first valid port after last_grant, wrapping to 0.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] sel;
        win_idx   = '0;
        win_found = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            sel = IDX_W'(idx);
            if (!win_found && req_valid[sel]) begin
                win_found = 1'b1;
                win_idx   = sel;
            end
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_next = state;
        req_grant  = '0;
        req_ack    = '0;
        tx_send_en = (state == LAUNCH);
        arb_busy   = (state != IDLE);
`ifdef UART_ARB_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        if (state != IDLE) req_grant[grant_idx] = 1'b1;
        if (state == DONE) req_ack[grant_idx] = 1'b1;
        case (state)
            IDLE: begin
                // A busy link may still be finishing a frame; never launch over it.
                if (!tx_busy && win_found) state_next = LAUNCH;
            end
            LAUNCH: state_next = WAIT_START;
            WAIT_START: begin
                if (tx_busy)
                    state_next = WAIT_DONE;
                else if (cnt == CNT_W'(BUSY_WAIT - 1))
                    state_next = DONE;
            end
            WAIT_DONE: begin
`ifdef UART_ARB_TIMEOUT_EN
                if (!tx_busy) begin
                    state_next = DONE;
                end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_next  = DONE;
                    timeout_hit = 1'b1;
                end
`else
                if (!tx_busy) state_next = DONE;
`endif
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register, grant/data capture, round-robin pointer and wait counter.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            grant_idx  <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            tx_data    <= '0;
            cnt        <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && state_next == LAUNCH) begin
                grant_idx <= win_idx;
                tx_data   <= req_data[win_idx*DATA_W +: DATA_W];
            end
            if (state == DONE) last_grant <= grant_idx;
            if (state_next != state)
                cnt <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            else if (state == WAIT_START || state == WAIT_DONE)
`else
            else if (state == WAIT_START)
`endif
                cnt <= cnt + 1'b1;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Sticky watchdog flag; only reset clears it.
    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            err_timeout <= 1'b0;
        else if (timeout_hit)
            err_timeout <= 1'b1;
    end
`else
    assign err_timeout = 1'b0;
`endif

endmodule
